// File: rtl/mpc_mem_responder.sv
// Line-granular memory model for the MPC cache external port: fixed-latency, in-order responses.
// Optional MPC_MEM_STORE_ACK_EN: stores also push an acknowledge response.
module mpc_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CL_WIDTH   = 512,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MC_SIZE    = 4,
  parameter int unsigned MEM_LINES  = 256,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_op_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [CL_WIDTH-1:0]   req_data_i,
  input  logic [ID_WIDTH-1:0]   req_id_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [2:0]            rsp_op_o,
  output logic [ID_WIDTH-1:0]   rsp_id_o,
  output logic [CL_WIDTH-1:0]   rsp_data_o,
  output logic                  rsp_err_o
);

  localparam int unsigned OffW = $clog2(CL_WIDTH / 8);
  localparam int unsigned IdxW = $clog2(MEM_LINES);
  localparam int unsigned PtrW = $clog2(MC_SIZE);
  localparam int unsigned CntW = $clog2(LATENCY + 1);

  localparam logic [2:0] OpLoad  = 3'd0;
  localparam logic [2:0] OpStore = 3'd1;

  logic [CL_WIDTH-1:0] mem_q [MEM_LINES];

  logic [2:0]          op_q   [MC_SIZE];
  logic [ID_WIDTH-1:0] id_q   [MC_SIZE];
  logic [CL_WIDTH-1:0] data_q [MC_SIZE];
  logic                err_q  [MC_SIZE];
  logic [CntW-1:0]     cnt_q  [MC_SIZE];

  logic [PtrW:0]   wptr_q, rptr_q;
  logic [PtrW-1:0] waddr, raddr;
  logic [IdxW-1:0] line_idx;
  logic            full, empty;
  logic            accept, push, pop;
  logic            is_load, is_store;

  logic unused_addr;
  assign unused_addr = ^{req_addr_i[ADDR_WIDTH-1:OffW+IdxW], req_addr_i[OffW-1:0]};

  assign waddr    = wptr_q[PtrW-1:0];
  assign raddr    = rptr_q[PtrW-1:0];
  assign line_idx = req_addr_i[OffW +: IdxW];

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) && (waddr == raddr);

  assign is_load  = (req_op_i == OpLoad);
  assign is_store = (req_op_i == OpStore);

  assign req_ready_o = !full;
  assign accept      = req_valid_i && req_ready_o;

`ifdef MPC_MEM_STORE_ACK_EN
  assign push = accept;
`else
  // Stores are posted: they consume a ready slot but never occupy the queue.
  assign push = accept && !is_store;
`endif

  assign rsp_valid_o = !empty && (cnt_q[raddr] == '0);
  assign pop         = rsp_valid_o && rsp_ready_i;

  assign rsp_op_o   = op_q[raddr];
  assign rsp_id_o   = id_q[raddr];
  assign rsp_data_o = data_q[raddr];
  assign rsp_err_o  = err_q[raddr];

  // Storage is intentionally not reset so stores survive a reset.
  always_ff @(posedge clk_i) begin
    if (accept && is_store) begin
      mem_q[line_idx] <= req_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < MC_SIZE; i++) begin
        op_q[i]   <= '0;
        id_q[i]   <= '0;
        data_q[i] <= '0;
        err_q[i]  <= 1'b0;
        cnt_q[i]  <= '0;
      end
    end else begin
      // Counting down idle slots is harmless: a push always reloads the count.
      for (int i = 0; i < MC_SIZE; i++) begin
        if (cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - CntW'(1);
        end
      end
      if (push) begin
        op_q[waddr]   <= req_op_i;
        id_q[waddr]   <= req_id_i;
        data_q[waddr] <= is_load ? mem_q[line_idx] : '0;
        err_q[waddr]  <= !(is_load || is_store);
        cnt_q[waddr]  <= CntW'(LATENCY - 1);
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mpc_mem_responder.sv
// Scoreboard bench for mpc_mem_responder: directed requests push expectations, a monitor pops them.
module tb_mpc_mem_responder;

  localparam int unsigned LATENCY = 4;

`ifdef MPC_MEM_STORE_ACK_EN
  localparam bit AckEn = 1'b1;
`else
  localparam bit AckEn = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [2:0]   req_op_i;
  logic [31:0]  req_addr_i;
  logic [511:0] req_data_i;
  logic [3:0]   req_id_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [2:0]   rsp_op_o;
  logic [3:0]   rsp_id_o;
  logic [511:0] rsp_data_o;
  logic         rsp_err_o;

  mpc_mem_responder #(
    .ADDR_WIDTH(32),
    .CL_WIDTH  (512),
    .ID_WIDTH  (4),
    .MC_SIZE   (4),
    .MEM_LINES (256),
    .LATENCY   (LATENCY)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_op_i   (req_op_i),
    .req_addr_i (req_addr_i),
    .req_data_i (req_data_i),
    .req_id_i   (req_id_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_op_o   (rsp_op_o),
    .rsp_id_o   (rsp_id_o),
    .rsp_data_o (rsp_data_o),
    .rsp_err_o  (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]   op;
    logic [3:0]   id;
    logic [511:0] data;
    logic         err;
    int           acc;
    bit           exact;
    bit           gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   last_pop = 0;
  int   errors = 0;
  int   checks = 0;

  localparam logic [511:0] DataA = {16{32'hA5A5_0000}};
  localparam logic [511:0] DataB = {16{32'h5A5A_FFFF}};
  localparam logic [511:0] DataC = {16{32'h1234_5678}};
  localparam logic [511:0] Junk  = {16{32'hDEAD_BEEF}};

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: a response is consumed at the edge following a negedge where valid && ready.
  always @(negedge clk_i) begin
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1'b1, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 512'(rsp_id_o), 512'(mon_e.id));
        check("rsp_op", 512'(rsp_op_o), 512'(mon_e.op));
        check("rsp_err", 512'(rsp_err_o), 512'(mon_e.err));
        check("rsp_data", rsp_data_o, mon_e.data);
        if (mon_e.exact) check("latency", 512'(cyc - mon_e.acc), 512'(LATENCY));
        else check("latency_min", 512'((cyc - mon_e.acc) >= LATENCY), 512'(1));
        if (mon_e.gap) check("b2b_gap", 512'(cyc - last_pop), 512'(1));
        last_pop = cyc;
      end
    end
  end

  // Called at #1 after a posedge; leaves req_valid_i high so calls can run back-to-back.
  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [511:0] data,
                      input logic [3:0] id, input logic [511:0] exp_data, input bit exact,
                      input bit gap);
    exp_t e;
    int   waited = 0;
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_addr_i  = addr;
    req_data_i  = data;
    req_id_i    = id;
    @(negedge clk_i);
    while (!req_ready_o && waited < 200) begin
      waited++;
      @(negedge clk_i);
    end
    if (!req_ready_o) begin
      check("accept_timeout", 1'b0, 1'b1);
    end else begin
      e.op    = op;
      e.id    = id;
      e.err   = (op > 3'd1);
      e.data  = (op == 3'd0) ? exp_data : '0;
      e.acc   = cyc;
      e.exact = exact;
      e.gap   = gap;
      if (op != 3'd1 || AckEn) exp_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req_valid_i = 1'b0;
    req_op_i    = '0;
    req_addr_i  = '0;
    req_data_i  = '0;
    req_id_i    = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk_i);
      n++;
    end
    check("drain", 512'(exp_q.size()), 512'(0));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i       = 1'b1;
    rsp_ready_i = 1'b1;
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_req_ready", 512'(req_ready_o), 512'(1));
    check("rst_rsp_valid", 512'(rsp_valid_o), 512'(0));
    check("rst_rsp_fields", {rsp_data_o[511:8], rsp_op_o, rsp_id_o, rsp_err_o}, 512'(0));
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Store then load the same line; load response lands exactly LATENCY after accept.
    send(3'd1, 32'h80, DataB, 4'd0, '0, 1'b0, 1'b0);
    send(3'd1, 32'h40, DataA, 4'd1, '0, 1'b0, 1'b0);
    send(3'd0, 32'h40, Junk, 4'd2, DataA, 1'b1, 1'b0);
    idle();
    drain();

    // Unsupported op: error response, storage untouched.
    send(3'd5, 32'h40, Junk, 4'd7, '0, 1'b1, 1'b0);
    send(3'd0, 32'h40, Junk, 4'd8, DataA, 1'b0, 1'b0);
    idle();
    drain();

    // Fill the queue with the response side stalled.
    rsp_ready_i = 1'b0;
    for (int i = 3; i <= 6; i++) send(3'd0, 32'h40, Junk, 4'(i), DataA, 1'b0, i != 3);
    idle();
    @(negedge clk_i);
    check("full_ready", 512'(req_ready_o), 512'(0));
    req_valid_i = 1'b1;
    req_op_i    = 3'd0;
    req_addr_i  = 32'h80;
    req_id_i    = 4'd9;
    repeat (3) begin
      @(negedge clk_i);
      check("stall_ready", 512'(req_ready_o), 512'(0));
    end
    @(posedge clk_i);
    #1;
    idle();
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("ready_pop_cycle", 512'(req_ready_o), 512'(0));
    @(negedge clk_i);
    check("ready_after_pop", 512'(req_ready_o), 512'(1));
    @(posedge clk_i);
    #1;
    send(3'd0, 32'h80, Junk, 4'd9, DataB, 1'b0, 1'b0);
    idle();
    drain();

    // Continuous load stream across many pointer wraps.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) send(3'd0, 32'h40, Junk, 4'(i % 16), DataA, i == 0, 1'b0);
      else send(3'd0, 32'h80, Junk, 4'(i % 16), DataB, 1'b0, 1'b0);
    end
    idle();
    drain();

    // Aliasing: 0x40 + MEM_LINES*64 maps to the same line as 0x40.
    send(3'd1, 32'h4040, DataC, 4'd10, '0, 1'b0, 1'b0);
    send(3'd0, 32'h40, Junk, 4'd11, DataC, 1'b0, 1'b0);
    idle();
    drain();

    // Reset with responses pending flushes the queue but not storage.
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(3'd0, 32'h80, Junk, 4'(12 + i), DataB, 1'b0, 1'b0);
    idle();
    repeat (6) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk_i);
    #1;
    check("flush_rsp_valid", 512'(rsp_valid_o), 512'(0));
    check("flush_req_ready", 512'(req_ready_o), 512'(1));
    rst_i       = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    send(3'd0, 32'h4040, Junk, 4'd15, DataC, 1'b1, 1'b0);
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mpc_mem_responder.md
Name: mpc_mem_responder

Overview:
- Memory-side responder for the MPC cache's external port: it receives `MEM_OP_LOAD` / `MEM_OP_STORE` requests issued by the cache.
- Services requests from an internal line-granular storage array with a fixed, programmable latency.
- Returns in-order responses through a queue of `MC_SIZE` entries.
- Serves as the memory model behind the cache in block- and subsystem-level benches, and as the reference memory endpoint for the external protocol.

Parameters:
- `ADDR_WIDTH`, 32, request byte-address width.
- `CL_WIDTH`, 512, cacheline width in bits; one request moves one full line.
- `ID_WIDTH`, 4, request tag width, echoed in the response.
- `MC_SIZE`, 4, response-queue depth; power of 2, ≥2.
- `MEM_LINES`, 256, storage depth in lines; power of 2.
- `LATENCY`, 4, cycles from request acceptance to earliest response-valid; ≥1.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready.
- `req_op_i`  in  3  `external_command_e` (0=LOAD, 1=STORE).
- `req_addr_i`  in  `ADDR_WIDTH`  byte address.
- `req_data_i`  in  `CL_WIDTH`  store line data.
- `req_id_i`  in  `ID_WIDTH`  request tag.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response ready.
- `rsp_op_o`  out  3  op of the responded request.
- `rsp_id_o`  out  `ID_WIDTH`  echoed tag.
- `rsp_data_o`  out  `CL_WIDTH`  load data; 0 for store and error responses.
- `rsp_err_o`  out  1  unsupported op.

Behaviour:
- One clock `clk_i`; reset `rst_i` is synchronous and active-high.
- Reset values:
  - Queue empty; `req_ready_o`=1; `rsp_valid_o`=0.
  - `rsp_op_o`, `rsp_id_o`, `rsp_data_o` and `rsp_err_o` all 0.
  - Storage contents are not reset.
- Line index = `req_addr_i[log2(CL_WIDTH/8) +: log2(MEM_LINES)]`. Low offset bits and upper address bits are ignored (aliasing).
- Handshake:
  - A request is accepted on a cycle where `req_valid_i` and `req_ready_o` are both high.
  - A response is consumed on a cycle where `rsp_valid_o` and `rsp_ready_i` are both high.
  - Request inputs need only be stable during the accept cycle.
  - Response outputs hold stable while `rsp_valid_o`=1 and `rsp_ready_i`=0.
- `req_ready_o` = !full. No same-cycle bypass: a pop in cycle T does not raise ready until T+1.
- Storage access happens at acceptance:
  - STORE: writes the line in the accept cycle.
  - LOAD: reads the line at the accept edge into the queue entry.
  - Hence a LOAD accepted after a STORE to the same line returns the new data. A LOAD and STORE to the same line cannot be accepted in the same cycle (one request per cycle).
- Unsupported op (`req_op_i` ∉ {0,1}): no storage access; entry pushed with `err`=1 and data 0.
- Queue entry fields: `{op, id, data, err, cnt}`.
  - `cnt` loads `LATENCY-1` on push.
  - Every valid entry's `cnt` decrements each cycle, saturating at 0.
- Response timing:
  - `rsp_valid_o` = !empty && head.`cnt`==0.
  - A request accepted in cycle T yields `rsp_valid_o`=1 no earlier than T+`LATENCY`.
  - Back-to-back accepts with `rsp_ready_i`=1 give one response per cycle.
  - Responses leave strictly in acceptance order; a later entry never overtakes the head.
- Pointers: read/write pointers of width log2(`MC_SIZE`)+1, with full/empty taken from the MSB compare; wrap-around is seamless.
- Simultaneous push and pop:
  - Allowed when not full; occupancy is unchanged.
  - When full, no push is possible that cycle.
- Reset mid-operation flushes all pending responses. Stores already written remain in storage.
- `rsp_data_o`, `rsp_op_o`, `rsp_id_o` and `rsp_err_o` come directly from the queue head register; there is no combinational path from request inputs to response outputs.

Optional Feature:
- Macro: `MPC_MEM_STORE_ACK_EN`.
- Defined: every accepted STORE pushes a queue entry and produces a response (`rsp_op_o`=1, data 0, `err`=0), subject to `LATENCY` and ordering like a LOAD.
- Undefined: STOREs write storage and push no entry, so they never block on a full queue for ack purposes, and only LOADs and error ops produce responses.
- Undefined, full queue: STORE acceptance still requires `req_ready_o`=1 (ready = !full), so ordering rules stay uniform.

Test Plan:
- STORE addr 0x40 data {16{32'hA5A5_0000}} id 1, then LOAD addr 0x40 id 2 (`LATENCY`=4, `rsp_ready_i`=1) -> LOAD response exactly 4 cycles after its accept, id 2, matching data, `err`=0. With `MPC_MEM_STORE_ACK_EN`, a STORE ack with id 1 precedes it.
- 4 LOADs (ids 3..6) with `rsp_ready_i`=0 -> `req_ready_o`=0 after the 4th accept, and a 5th request stalls. Raise `rsp_ready_i` -> ids 3,4,5,6 in order on consecutive cycles; `req_ready_o` returns the cycle after the first pop.
- Continuous LOAD stream of 20 requests with `rsp_ready_i`=1 -> after 4-cycle fill, one response per cycle and ids in order across ≥4 pointer wraps.
- `req_op_i`=3'd5, id 7 -> response `err`=1, `rsp_data_o`=0, id 7; storage unchanged (verify with a subsequent LOAD).
- Addresses 0x40 and 0x40+`MEM_LINES`*64 -> alias to the same line: a STORE to one is visible to a LOAD from the other.
- Reset asserted with 3 pending responses -> next cycle `rsp_valid_o`=0, `req_ready_o`=1; a LOAD after reset returns pre-reset stored data.
